// File: rtl/asrv32_stage_controller.sv
// Multi-cycle stage sequencer for the ASRV32 core: steps each instruction through
// fetch/decode/execute/memory/writeback with bus handshakes, timeout abort, trap flush and retire count.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET     | held in reset; leaves for FETCH on the first clock after release
// FETCH     | instruction request outstanding, waiting on i_inst_ack
// DECODE    | single-cycle decode
// EXECUTE   | single-cycle execute; picks MEMORY for loads/stores, else WRITEBACK
// MEMORY    | data request outstanding, waiting on i_data_ack
// WRITEBACK | single-cycle PC/rd update; retires the instruction

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module asrv32_stage_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] PC_RESET       = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [`OPCODE_WIDTH-1:0] i_opcode,
  input  logic                     i_stall,
  input  logic                     i_trap,
  input  logic                     i_inst_ack,
  input  logic                     i_data_ack,
  output logic [2:0]               o_stage,
  output logic                     o_fetch_en,
  output logic                     o_decode_en,
  output logic                     o_execute_en,
  output logic                     o_memory_en,
  output logic                     o_writeback_en,
  output logic                     o_inst_req,
  output logic                     o_data_req,
  output logic                     o_data_we,
  output logic                     o_bus_err,
  output logic [31:0]              o_retire_count
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  localparam bit          tmo_en   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] tmo_last = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        data_we_q, data_we_d;
  logic        bus_err_q;
  logic [31:0] retire_count_q;
  logic        waiting, ack, tmo_hit, wb_fire;

  // PC_RESET is carried for consistency with the core only; the opcode is only partly decoded
  logic unused_bits;
  assign unused_bits = ^{i_opcode, PC_RESET};

  // Acks count only in the state that owns the matching request
  always_comb begin
    waiting = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
    ack     = 1'b0;
    if (state_q == ST_FETCH)  ack = i_inst_ack;
    if (state_q == ST_MEMORY) ack = i_data_ack;
    tmo_hit = tmo_en && waiting && !i_trap && !i_stall && !ack && (tmo_cnt_q == tmo_last);
    wb_fire = (state_q == ST_WRITEBACK) && !i_stall && !i_trap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_RESET;
      tmo_cnt_q      <= '0;
      data_we_q      <= 1'b0;
      bus_err_q      <= 1'b0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      data_we_q      <= data_we_d;
      bus_err_q      <= tmo_hit;
      if (wb_fire) retire_count_q <= retire_count_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RESET)  state_d = ST_FETCH;
    else if (i_trap)          state_d = ST_FETCH;
    else if (i_stall)         state_d = state_q;
    else if (tmo_hit)         state_d = ST_FETCH;
    else begin
      case (state_q)
        ST_FETCH:     if (i_inst_ack) state_d = ST_DECODE;
        ST_DECODE:    state_d = ST_EXECUTE;
        ST_EXECUTE:   state_d = (i_opcode[`LOAD] || i_opcode[`STORE]) ? ST_MEMORY : ST_WRITEBACK;
        ST_MEMORY:    if (i_data_ack) state_d = ST_WRITEBACK;
        ST_WRITEBACK: state_d = ST_FETCH;
        default:      state_d = ST_RESET;
      endcase
    end

    // Any exit from a waiting state (ack, timeout, trap) leaves the counter at zero for the next entry
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_RESET || i_trap)       tmo_cnt_d = '0;
    else if (i_stall)                        tmo_cnt_d = tmo_cnt_q;
    else if (waiting && !ack && !tmo_hit)    tmo_cnt_d = tmo_cnt_q + 16'd1;
    else                                     tmo_cnt_d = '0;

    data_we_d = data_we_q;
    if (state_q == ST_EXECUTE && state_d == ST_MEMORY)     data_we_d = i_opcode[`STORE];
    else if (state_q == ST_MEMORY && state_d != ST_MEMORY) data_we_d = 1'b0;
  end

  always_comb begin
    o_stage        = state_q;
    o_fetch_en     = (state_q == ST_FETCH);
    o_decode_en    = (state_q == ST_DECODE);
    o_execute_en   = (state_q == ST_EXECUTE);
    o_memory_en    = (state_q == ST_MEMORY);
    o_writeback_en = wb_fire;
    o_inst_req     = (state_q == ST_FETCH);
    o_data_req     = (state_q == ST_MEMORY);
    o_data_we      = data_we_q;
    o_bus_err      = bus_err_q;
    o_retire_count = retire_count_q;
  end

endmodule

// File: tb/tb_asrv32_stage_controller.sv
// Directed bench for asrv32_stage_controller with TIMEOUT_CYCLES=4:
// sequencing, memory handshakes, stall, timeouts, trap, async reset and retire-count wrap.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module tb_asrv32_stage_controller;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n;
  logic [`OPCODE_WIDTH-1:0] i_opcode;
  logic                     i_stall, i_trap, i_inst_ack, i_data_ack;
  logic [2:0]               o_stage;
  logic                     o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_writeback_en;
  logic                     o_inst_req, o_data_req, o_data_we, o_bus_err;
  logic [31:0]              o_retire_count;

  int checks = 0;
  int errors = 0;
  int cnt;

  logic [`OPCODE_WIDTH-1:0] op_add, op_load, op_store;

  asrv32_stage_controller #(.TIMEOUT_CYCLES(4), .PC_RESET(32'h0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_stall(i_stall),
    .i_trap(i_trap), .i_inst_ack(i_inst_ack), .i_data_ack(i_data_ack),
    .o_stage(o_stage), .o_fetch_en(o_fetch_en), .o_decode_en(o_decode_en),
    .o_execute_en(o_execute_en), .o_memory_en(o_memory_en), .o_writeback_en(o_writeback_en),
    .o_inst_req(o_inst_req), .o_data_req(o_data_req), .o_data_we(o_data_we),
    .o_bus_err(o_bus_err), .o_retire_count(o_retire_count)
  );

  always #5 i_clk = ~i_clk;

  // {fetch, decode, execute, memory, writeback, inst_req, data_req, data_we, bus_err}
  function automatic logic [31:0] outs();
    return {23'd0, o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_writeback_en,
            o_inst_req, o_data_req, o_data_we, o_bus_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    op_add   = '0; op_add[0] = 1'b1;
    op_load  = '0; op_load[`LOAD] = 1'b1;
    op_store = '0; op_store[`STORE] = 1'b1;

    i_rst_n = 1'b0; i_opcode = op_add; i_stall = 1'b0; i_trap = 1'b0;
    i_inst_ack = 1'b1; i_data_ack = 1'b1;
    #1;
    check("reset_stage", 32'(o_stage), 32'd0);
    check("reset_outs", outs(), 32'h0);
    check("reset_retire", o_retire_count, 32'd0);
    tick(); tick();
    check("held_reset_stage", 32'(o_stage), 32'd0);
    i_rst_n = 1'b1;

    // ADD with acks tied high: 1,2,3,5,1
    tick(); check("add_fetch", 32'(o_stage), 32'd1);
    check("add_fetch_outs", outs(), 32'b100001000);
    cnt = 0;
    tick(); check("add_decode", 32'(o_stage), 32'd2);
    check("add_decode_outs", outs(), 32'b010000000); cnt += int'(o_writeback_en);
    tick(); check("add_execute", 32'(o_stage), 32'd3);
    check("add_execute_outs", outs(), 32'b001000000); cnt += int'(o_writeback_en);
    tick(); check("add_writeback", 32'(o_stage), 32'd5);
    check("add_wb_outs", outs(), 32'b000010000); cnt += int'(o_writeback_en);
    tick(); check("add_next_fetch", 32'(o_stage), 32'd1); cnt += int'(o_writeback_en);
    check("add_wb_pulses", 32'(cnt), 32'd1);
    check("add_retire", o_retire_count, 32'd1);

    // LOAD, data ack arrives on the 4th MEMORY cycle (also the timeout-expiry cycle)
    i_opcode = op_load; i_data_ack = 1'b0;
    tick(); tick();
    cnt = 0;
    tick(); check("load_mem_stage", 32'(o_stage), 32'd4);
    check("load_mem_outs", outs(), 32'b000100100); cnt += int'(o_data_req);
    tick(); cnt += int'(o_data_req);
    tick(); cnt += int'(o_data_req);
    tick(); i_data_ack = 1'b1; cnt += int'(o_data_req);
    check("load_last_wait_stage", 32'(o_stage), 32'd4);
    tick(); cnt += int'(o_data_req);
    check("load_req_cycles", 32'(cnt), 32'd4);
    check("load_wb_stage", 32'(o_stage), 32'd5);
    check("load_ack_on_expiry_no_err", 32'(o_bus_err), 32'd0);
    tick(); check("load_retire", o_retire_count, 32'd2);

    // STORE
    i_opcode = op_store;
    tick(); tick(); tick();
    check("store_mem_outs", outs(), 32'b000100110);
    tick(); check("store_wb_stage", 32'(o_stage), 32'd5);
    check("store_we_cleared", 32'(o_data_we), 32'd0);
    tick(); check("store_retire", o_retire_count, 32'd3);

    // Stall 5 cycles in WRITEBACK
    i_opcode = op_add;
    tick(); tick(); tick();
    check("stall_wb_stage", 32'(o_stage), 32'd5);
    i_stall = 1'b1; #1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cnt += int'(o_writeback_en);
      tick();
    end
    check("stall_wb_pulses", 32'(cnt), 32'd0);
    check("stall_hold_stage", 32'(o_stage), 32'd5);
    check("stall_hold_retire", o_retire_count, 32'd3);
    i_stall = 1'b0; #1;
    check("stall_release_wb", 32'(o_writeback_en), 32'd1);
    tick(); check("stall_retire_plus1", o_retire_count, 32'd4);
    check("stall_next_fetch", 32'(o_stage), 32'd1);

    // STORE in MEMORY with no ack: timeout after 4 waiting cycles
    i_opcode = op_store; i_data_ack = 1'b0;
    tick(); tick(); tick();
    check("tmo_mem_stage", 32'(o_stage), 32'd4);
    check("tmo_mem_we", 32'(o_data_we), 32'd1);
    tick(); tick(); tick();
    check("tmo_no_err_yet", 32'(o_bus_err), 32'd0);
    check("tmo_still_mem", 32'(o_stage), 32'd4);
    tick(); check("tmo_abort_fetch", 32'(o_stage), 32'd1);
    check("tmo_bus_err_pulse", 32'(o_bus_err), 32'd1);
    check("tmo_we_cleared", 32'(o_data_we), 32'd0);
    check("tmo_retire_unchanged", o_retire_count, 32'd4);

    // FETCH timeout retries the fetch
    i_inst_ack = 1'b0; i_data_ack = 1'b1;
    tick(); check("ftmo_err_single", 32'(o_bus_err), 32'd0);
    tick(); tick();
    check("ftmo_waiting", 32'(o_stage), 32'd1);
    tick(); check("ftmo_retry_fetch", 32'(o_stage), 32'd1);
    check("ftmo_bus_err", 32'(o_bus_err), 32'd1);
    i_inst_ack = 1'b1;
    tick(); check("ftmo_decode", 32'(o_stage), 32'd2);

    // Trap in EXECUTE of a STORE
    tick(); check("trap_in_exec", 32'(o_stage), 32'd3);
    i_trap = 1'b1; #1;
    check("trap_no_wb", 32'(o_writeback_en), 32'd0);
    tick(); i_trap = 1'b0;
    check("trap_fetch", 32'(o_stage), 32'd1);
    check("trap_no_data_req", 32'(o_data_req), 32'd0);
    check("trap_no_we", 32'(o_data_we), 32'd0);
    check("trap_retire", o_retire_count, 32'd4);

    // Async reset mid-MEMORY
    i_opcode = op_load; i_data_ack = 1'b0;
    tick(); tick(); tick();
    check("arst_in_mem", 32'(o_stage), 32'd4);
    #2 i_rst_n = 1'b0; #1;
    check("arst_stage", 32'(o_stage), 32'd0);
    check("arst_outs", outs(), 32'h0);
    check("arst_retire", o_retire_count, 32'd0);
    #1 i_rst_n = 1'b1;
    tick(); check("arst_release_fetch", 32'(o_stage), 32'd1);

    // Retire wrap from 0xFFFFFFFE, three ADDs
    i_opcode = op_add; i_data_ack = 1'b1;
    force dut.retire_count_q = 32'hFFFF_FFFE;
    release dut.retire_count_q;
    repeat (4) tick();
    check("wrap_ffffffff", o_retire_count, 32'hFFFF_FFFF);
    repeat (4) tick();
    check("wrap_zero", o_retire_count, 32'h0000_0000);
    repeat (4) tick();
    check("wrap_one", o_retire_count, 32'h0000_0001);
    check("wrap_fetch", 32'(o_stage), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
